// File: rtl/mem_stall_if.sv
// Handshake bundle between the MEM-stage pipeline, data memory and the stall controller.
interface mem_stall_if;
  logic       mem_rd;
  logic       mem_wr;
  logic       dmem_ready;
  logic       dmem_req;
  logic       dmem_we;
  logic       stall;
  logic       wb_bubble;
  logic [7:0] wait_cnt;
  logic       timeout_err;

  modport master (
    output mem_rd, mem_wr, dmem_ready,
    input  dmem_req, dmem_we, stall, wb_bubble, wait_cnt, timeout_err
  );

  modport slave (
    input  mem_rd, mem_wr, dmem_ready,
    output dmem_req, dmem_we, stall, wb_bubble, wait_cnt, timeout_err
  );
endinterface

// File: rtl/mem_stall_ctrl.sv
// Data-memory wait-state controller: stalls the pipeline while an access is outstanding.
// Optional watchdog on wait states is enabled by defining MEM_TIMEOUT_EN.
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic        clk,
  input logic        rst,
  mem_stall_if.slave bus
);

`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       we_lat, we_lat_nxt;
  logic       to_err, to_set;
  logic       op, to_hit;

  assign op     = bus.mem_rd | bus.mem_wr;
  assign to_hit = TO_EN && ({24'd0, cnt} >= TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      we_lat <= 1'b0;
      to_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      we_lat <= we_lat_nxt;
      if (to_set) to_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    we_lat_nxt    = we_lat;
    to_set        = 1'b0;
    bus.dmem_req  = op;
    bus.dmem_we   = bus.mem_wr & ~bus.mem_rd;
    bus.stall     = 1'b0;
    bus.wb_bubble = 1'b0;
    case (state)
      IDLE: begin
        if (op && !bus.dmem_ready) begin
          bus.stall     = 1'b1;
          bus.wb_bubble = 1'b1;
          state_nxt     = ACCESS;
          cnt_nxt       = 8'd1;
          we_lat_nxt    = bus.mem_wr & ~bus.mem_rd;
        end
      end
      ACCESS: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = we_lat;
        if (!op) begin
          // withdrawn request: drop the bus, release the pipe, squash WB
          bus.dmem_req  = 1'b0;
          bus.dmem_we   = 1'b0;
          bus.wb_bubble = 1'b1;
          state_nxt     = IDLE;
          cnt_nxt       = 8'd0;
        end else if (bus.dmem_ready) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end else if (to_hit) begin
          bus.wb_bubble = 1'b1;
          to_set        = 1'b1;
          state_nxt     = IDLE;
          cnt_nxt       = 8'd0;
        end else begin
          bus.stall     = 1'b1;
          bus.wb_bubble = 1'b1;
          if (cnt != 8'hFF) cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // nothing advances while reset is held, so never report a stall then
    if (rst) begin
      bus.stall     = 1'b0;
      bus.wb_bubble = 1'b0;
    end
  end

  assign bus.wait_cnt    = cnt;
  assign bus.timeout_err = to_err & TO_EN;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed + randomized bench for mem_stall_ctrl against a transaction-level reference model.
module tb_mem_stall_ctrl;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int TB_TO = 4;
`else
  localparam bit TO_EN = 1'b0;
  localparam int TB_TO = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // model: number of wait cycles spent on the outstanding access (0 = none)
  int m_wait = 0;
  bit m_we   = 1'b0;
  bit m_err  = 1'b0;

  mem_stall_if bus();
  mem_stall_ctrl #(.TIMEOUT_CYCLES(TB_TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic cycle(input bit rd, input bit wr, input bit rdy);
    bit op, e_req, e_we, e_stall, e_bub;
    int e_cnt;
    bus.mem_rd = rd; bus.mem_wr = wr; bus.dmem_ready = rdy;
    #1;
    op = rd | wr; e_cnt = m_wait;
    e_req = op; e_we = wr && !rd; e_stall = 1'b0; e_bub = 1'b0;
    if (m_wait == 0) begin
      e_stall = op && !rdy; e_bub = e_stall;
      if (e_stall) begin m_wait = 1; m_we = e_we; end
    end else if (!op) begin
      e_req = 1'b0; e_we = 1'b0; e_bub = 1'b1; m_wait = 0;
    end else begin
      e_req = 1'b1; e_we = m_we;
      if (rdy) m_wait = 0;
      else if (TO_EN && m_wait >= TB_TO) begin e_bub = 1'b1; m_err = 1'b1; m_wait = 0; end
      else begin e_stall = 1'b1; e_bub = 1'b1; if (m_wait < 255) m_wait++; end
    end
    chk("dmem_req", 32'(bus.dmem_req), 32'(e_req));
    if (e_req) chk("dmem_we", 32'(bus.dmem_we), 32'(e_we));
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("wb_bubble", 32'(bus.wb_bubble), 32'(e_bub));
    chk("wait_cnt", 32'(bus.wait_cnt), 32'(e_cnt));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_err & TO_EN));
    @(posedge clk); #1;
  endtask

  initial begin
    bit rd, wr;
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.dmem_ready = 1'b0;
    #2;
    chk("rst_wait_cnt", 32'(bus.wait_cnt), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_terr", 32'(bus.timeout_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    cycle(1, 0, 1);                                  // zero-wait load
    cycle(0, 1, 0); cycle(0, 1, 0); cycle(0, 1, 0);  // store, 3 wait states
    cycle(0, 1, 1);
    cycle(1, 1, 0); cycle(1, 1, 0); cycle(1, 1, 1);  // both high -> load
    cycle(1, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0);  // abort after 2 waits
    cycle(0, 0, 0);
    cycle(0, 1, 0); cycle(0, 1, 1); cycle(1, 0, 0);  // back-to-back
    cycle(1, 0, 1); cycle(1, 0, 1);

    // async reset with an access in flight at wait_cnt=5
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);
    chk("pre_rst_cnt", 32'(bus.wait_cnt), 32'd5);
    bus.mem_wr = 1'b1; bus.dmem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(bus.wait_cnt), 32'd0);
    chk("async_rst_stall", 32'(bus.stall), 32'd0);
    chk("async_rst_bubble", 32'(bus.wb_bubble), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; m_wait = 0; m_we = 1'b0; m_err = 1'b0;
    cycle(1, 0, 1);

`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);      // watchdog fires at wait_cnt=TB_TO
    chk("terr_set", 32'(bus.timeout_err), 32'd1);
    cycle(1, 0, 1); cycle(0, 0, 0);
`else
    for (int i = 0; i < 262; i++) cycle(1, 0, 0);    // saturation at 255
    chk("sat_cnt", 32'(bus.wait_cnt), 32'd255);
    cycle(1, 0, 1);
`endif

    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0 || m_wait == 0) begin
        rd = ($urandom_range(0, 2) == 0);
        wr = ($urandom_range(0, 2) == 0);
      end
      cycle(rd, wr, $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the wait-state limit used only when MEM_TIMEOUT_EN is defined.
REQ-002 clk  input  1  pipeline clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mem_rd  input  1  MEM-stage instruction is a load (MemRead).
REQ-005 mem_wr  input  1  MEM-stage instruction is a store (MemWrite).
REQ-006 dmem_ready  input  1  data memory completes the current access this cycle.
REQ-007 dmem_req  output  1  access request to data memory.
REQ-008 dmem_we  output  1  write enable to data memory; valid only while dmem_req=1.
REQ-009 stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-010 wb_bubble  output  1  forces WB control bits into MEM/WB to 2'b00 for this cycle.
REQ-011 wait_cnt  output  8  wait states spent on the current access; saturates at 255.
REQ-012 timeout_err  output  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN.

Function
REQ-013 The controller SHALL be a Moore/Mealy FSM with states IDLE and ACCESS, encoded in 1 bit.
REQ-014 Access request: op = mem_rd | mem_wr; mem_rd SHALL have priority, so when both are high dmem_we=0.
REQ-015 In IDLE, dmem_req SHALL equal op, and dmem_we SHALL equal mem_wr & ~mem_rd.
REQ-016 IDLE with op=1 and dmem_ready=1 is a zero-wait access: stall=0, wb_bubble=0, and the state stays IDLE.
REQ-017 IDLE with op=1 and dmem_ready=0: stall=1 and wb_bubble=1 combinationally; next state ACCESS; wait_cnt becomes 1.
REQ-018 In ACCESS, dmem_req SHALL be 1, dmem_we SHALL be held at the registered value latched on entry, and stall=1 and wb_bubble=1 while dmem_ready=0.
REQ-019 ACCESS with dmem_ready=1: stall=0 and wb_bubble=0 in that same cycle, so MEM/WB captures the load data at the next edge; next state IDLE; wait_cnt clears to 0.
REQ-020 ACCESS with dmem_ready=0: wait_cnt increments by 1, saturating at 255 without wrap.
REQ-021 ACCESS with op=0 (request withdrawn) SHALL abort: next state IDLE, stall=0, wb_bubble=1, dmem_req=0, wait_cnt cleared.
REQ-022 Back-to-back accesses: on the cycle after a completion, the controller SHALL be in IDLE and evaluate the new op with no dead cycle.
REQ-023 Latency from op assertion to stall release SHALL be N cycles, where N is the number of cycles dmem_ready stays low.

Reset
REQ-024 rst=1 SHALL force the following regardless of clk: state=IDLE, wait_cnt=0, latched dmem_we=0, timeout_err=0.
REQ-025 During reset, outputs SHALL follow the IDLE equations; an access in flight at reset is abandoned without any completion pulse.
REQ-026 The first post-reset edge SHALL behave as an ordinary IDLE cycle.

Configuration
REQ-027 Macro MEM_TIMEOUT_EN SHALL enable the timeout logic when defined.
REQ-028 With MEM_TIMEOUT_EN defined: in ACCESS, when wait_cnt reaches TIMEOUT_CYCLES with dmem_ready=0, the controller SHALL set timeout_err=1 (sticky until rst), force stall=0 and wb_bubble=1 for that cycle, and return to IDLE.
REQ-029 Without MEM_TIMEOUT_EN: timeout_err SHALL be tied to 0, and the controller SHALL wait indefinitely.

Verification
REQ-030 Zero-wait load: mem_rd=1 with dmem_ready=1 in the same cycle -> dmem_req=1, dmem_we=0, stall=0, wb_bubble=0, state stays IDLE.
REQ-031 Store with 3 wait states: mem_wr=1 and dmem_ready low for 3 cycles, then high -> stall=1 for 3 cycles, dmem_we=1 throughout, wait_cnt 1,2,3, then stall=0 and wait_cnt=0.
REQ-032 Both mem_rd=1 and mem_wr=1 -> dmem_we=0, handled as a load.
REQ-033 Abort: op drops after 2 wait cycles -> next cycle IDLE, stall=0, wb_bubble=1, dmem_req=0.
REQ-034 Reset mid-access: rst pulsed asynchronously during ACCESS with wait_cnt=5 -> wait_cnt=0 and stall=0 immediately, without waiting for clk.
REQ-035 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: dmem_ready held at 0 -> at wait_cnt=4, timeout_err=1 and stall=0, then state IDLE; timeout_err stays 1 until rst.
